// File: rtl/des_expansion_inverse.sv
// Inverse of the DES E expansion: recovers the 32-bit half-block from a 48-bit
// expanded word and cross-checks the duplicated edge bits. Optional macro DES_EXPINV_SQUASH_EN drops faulty words.
module des_expansion_inverse #(
  parameter int FAULT_CNT_W = 8
) (
  input  logic                   wClk,
  input  logic                   wRst_n,
  input  logic [47:0]            wInData,
  input  logic                   wInValid,
  output logic                   rInReady,
  output logic [31:0]            rOutData,
  output logic [15:0]            rOutMismatch,
  output logic                   rOutError,
  output logic                   rOutValid,
  input  logic                   wOutReady,
  input  logic                   wClearFault,
  output logic                   rFaultSticky,
  output logic [FAULT_CNT_W-1:0] rFaultCount
);

  localparam logic [FAULT_CNT_W-1:0] CntMax = {FAULT_CNT_W{1'b1}};

  logic [31:0]            out_data_q, out_data_d;
  logic [15:0]            out_mism_q, out_mism_d;
  logic                   out_err_q, out_err_d;
  logic                   out_valid_q, out_valid_d;
  logic                   sticky_q, sticky_d;
  logic [FAULT_CNT_W-1:0] count_q, count_d;

  logic [31:0] rec_data;
  logic [15:0] mism;
  logic        faulty;
  logic        accept;

  assign rInReady = !out_valid_q || wOutReady;
  assign accept   = wInValid && rInReady;

  // DES numbering is MSB-first from 1: DES bit n of an N-bit vector is index N-n.
  always_comb begin
    rec_data = '0;
    mism     = '0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 1; i <= 4; i++) begin
        rec_data[32-(4*k+i)] = wInData[48-(6*k+1+i)];
      end
      mism[16-(2*k+1)] = wInData[48-(6*k+1)] ^ wInData[48-(6*((k+7)%8)+5)];
      mism[16-(2*k+2)] = wInData[48-(6*k+6)] ^ wInData[48-(6*((k+1)%8)+2)];
    end
    faulty = |mism;
  end

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latches).
    out_data_d  = out_data_q;
    out_mism_d  = out_mism_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    sticky_d    = sticky_q;
    count_d     = count_q;

    if (out_valid_q && wOutReady) out_valid_d = 1'b0;

`ifdef DES_EXPINV_SQUASH_EN
    if (accept && !faulty) begin
`else
    if (accept) begin
`endif
      out_valid_d = 1'b1;
      out_data_d  = rec_data;
      out_mism_d  = mism;
      out_err_d   = faulty;
    end

    // Clear has priority over a coincident faulty accept.
    if (wClearFault) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end else if (accept && faulty) begin
      sticky_d = 1'b1;
      if (count_q != CntMax) count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge wClk or negedge wRst_n) begin
    if (!wRst_n) begin
      out_data_q  <= '0;
      out_mism_q  <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_mism_q  <= out_mism_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
    end
  end

  assign rOutData     = out_data_q;
  assign rOutMismatch = out_mism_q;
  assign rOutError    = out_err_q;
  assign rOutValid    = out_valid_q;
  assign rFaultSticky = sticky_q;
  assign rFaultCount  = count_q;

endmodule
